// File: rtl/map_port_arbiter.sv
// map_port_arbiter
// Shares the single read/write port B of the map BRAM between the player
// (index 0, tile read-modify-write) and the floor loader (index 1, floor
// copies). Only one access is in flight at a time. Arbitration is round-robin.
// A requester may lock the port across several accesses, and a lock held idle
// for too long is released by force.
module map_port_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1,   // 1..3 cycles from bram_addr to valid bram_dout
  parameter int MAX_HOLD = 16   // idle locked cycles before forced release
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [1:0]            lock,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  lock_timeout,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic                  bram_we,
  output logic [DATA_W-1:0]     bram_din,
  input  logic [DATA_W-1:0]     bram_dout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;

  localparam int WAIT_W = $clog2(READ_LAT + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LAT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [2:0]        state, state_d;
  logic              owner;       // requester that currently holds the port
  logic              rr_ptr;      // requester preferred when both ask
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  logic              take;        // accept a request at this edge
  logic              pick;        // requester accepted when take is set
  logic              timeout_hit; // locked owner idled out this cycle

  // Next-state decode: arbitration in IDLE, owner-only service in LOCKED.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d     = state;
    take        = 1'b0;
    pick        = owner;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          take    = 1'b1;
          pick    = (req == 2'b11) ? rr_ptr : req[1];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = we_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = lock[owner] ? S_LOCKED : S_IDLE;
      end
      S_LOCKED: begin
        if (req[owner]) begin
          take    = 1'b1;
          pick    = owner;
          state_d = S_ISSUE;
        end else if (!lock[owner]) begin
          state_d = S_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request capture, latency and hold counters, read-data capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      wait_cnt  <= '0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_d;
      timeout_q <= timeout_hit;

      if (take) begin
        owner  <= pick;
        rr_ptr <= ~pick;
        we_q   <= we[pick];
        addr_q <= pick ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
        din_q  <= pick ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      end

      if (state == S_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                 wait_cnt <= '0;

      if (state == S_WAIT && wait_cnt == WAIT_LAST) rdata_q <= bram_dout;

      // Counts consecutive locked cycles in which the owner asked for nothing.
      if (state == S_LOCKED && state_d == S_LOCKED) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                                          hold_cnt <= '0;
    end
  end

  assign gnt[0]       = (state == S_ISSUE) && !owner;
  assign gnt[1]       = (state == S_ISSUE) &&  owner;
  assign done[0]      = (state == S_RESP)  && !owner;
  assign done[1]      = (state == S_RESP)  &&  owner;
  assign rdata        = rdata_q;
  assign busy         = (state != S_IDLE);
  assign lock_timeout = timeout_q;
  assign bram_addr    = addr_q;
  assign bram_din     = din_q;
  assign bram_we      = (state == S_ISSUE) && we_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Testbench for map_port_arbiter: BRAM behavioural model on port B, a
// transaction-scheduling reference model compared every cycle, and directed
// scenarios with hand-computed cycle-exact expectations.
module tb_map_port_arbiter;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int RL = 1;
  localparam int MH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     req = '0;
  logic [1:0]     we = '0;
  logic [1:0]     lock = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]     gnt, done;
  logic [DW-1:0]  rdata;
  logic           busy, lock_timeout;
  logic [AW-1:0]  bram_addr;
  logic           bram_we;
  logic [DW-1:0]  bram_din;
  logic [DW-1:0]  bram_dout;

  int n_checks = 0;
  int n_errors = 0;

  map_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .lock_timeout(lock_timeout), .bram_addr(bram_addr), .bram_we(bram_we),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // Map BRAM port B: synchronous write, read data after RL edges.
  bit [DW-1:0] bram_mem [0:(1<<AW)-1];
  bit [DW-1:0] dout_pipe [RL];
  always @(posedge clk) begin
    if (bram_we) bram_mem[bram_addr] <= bram_din;
    dout_pipe[0] <= bram_mem[bram_addr];
    for (int i = 1; i < RL; i++) dout_pipe[i] <= dout_pipe[i-1];
  end
  assign bram_dout = dout_pipe[RL-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted request becomes a transaction with a grant cycle and a done
  // cycle computed from the latency rules; outputs follow from those numbers.
  bit [DW-1:0] model_mem [0:(1<<AW)-1];
  int          cyc = 0;
  bit          m_valid = 0;
  bit          acc_on = 0;
  int          acc_o, acc_start, acc_end;
  bit          acc_we;
  logic [DW-1:0] acc_rd;
  int          lock_o = -1;
  int          idle_run = 0;
  int          rr_last = 1;
  logic [1:0]  e_gnt, e_done;
  logic        e_busy, e_lt, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_rdata;

  function automatic logic [AW-1:0] addr_of(input int i);
    return (i == 1) ? addr[2*AW-1:AW] : addr[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return (i == 1) ? wdata[2*DW-1:DW] : wdata[DW-1:0];
  endfunction

  task automatic start_acc(input int o);
    acc_on    = 1;
    acc_o     = o;
    acc_we    = we[o];
    acc_start = cyc + 1;
    acc_end   = cyc + 2 + (we[o] ? 0 : RL);
    rr_last   = o;
    e_addr    = addr_of(o);
    e_din     = data_of(o);
    if (we[o]) model_mem[addr_of(o)] = data_of(o);
    else       acc_rd = model_mem[addr_of(o)];
  endtask

  initial begin
    forever begin
      @(posedge clk);
      e_lt = 1'b0;
      if (rst) begin
        m_valid  = 1;
        acc_on   = 0;
        lock_o   = -1;
        idle_run = 0;
        rr_last  = 1;
        e_addr   = '0;
        e_din    = '0;
        e_rdata  = '0;
      end else if (m_valid) begin
        if (acc_on) begin
          if (cyc == acc_end) begin
            acc_on = 0;
            if (lock[acc_o]) begin lock_o = acc_o; idle_run = 0; end
            else lock_o = -1;
          end
        end else if (lock_o >= 0) begin
          if (req[lock_o]) start_acc(lock_o);
          else if (!lock[lock_o]) lock_o = -1;
          else begin
            idle_run++;
            if (idle_run == MH) begin lock_o = -1; e_lt = 1'b1; end
          end
        end else if (req != 2'b00) begin
          if (req == 2'b11) start_acc(1 - rr_last);
          else              start_acc(req[1] ? 1 : 0);
        end
      end
      cyc++;
      e_gnt  = 2'b00;
      e_done = 2'b00;
      e_we   = 1'b0;
      if (acc_on && cyc == acc_start) begin e_gnt[acc_o] = 1'b1; e_we = acc_we; end
      if (acc_on && cyc == acc_end) begin
        e_done[acc_o] = 1'b1;
        if (!acc_we) e_rdata = acc_rd;
      end
      e_busy = acc_on || (lock_o >= 0);
    end
  end

  // Compare process: DUT against model on the falling edge of every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("m_gnt", gnt, e_gnt);
        check("m_done", done, e_done);
        check("m_busy", busy, e_busy);
        check("m_lock_timeout", lock_timeout, e_lt);
        check("m_bram_we", bram_we, e_we);
        check("m_bram_addr", bram_addr, e_addr);
        check("m_bram_din", bram_din, e_din);
        check("m_rdata", rdata, e_rdata);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit l);
    if (i == 0) begin addr[AW-1:0] = a; wdata[DW-1:0] = d; end
    else begin addr[2*AW-1:AW] = a; wdata[2*DW-1:DW] = d; end
    we[i]   = w;
    lock[i] = l;
    req[i]  = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20 && busy; k++) tick();
    check("wait_idle", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, g0, g1;
    bram_mem[19'h00123]  = 16'hBEEF;
    model_mem[19'h00123] = 16'hBEEF;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_bram_addr", bram_addr, 19'h0);
    rst = 1'b0;

    // Test 1: read idx0 0x00123 -> gnt T+1, done T+3, rdata 0xBEEF.
    set_req(0, 1'b0, 19'h00123, 16'h0, 1'b0);
    tick(); check("t1_gnt", gnt, 2'b01); check("t1_addr", bram_addr, 19'h00123); req = 2'b00;
    tick(); check("t1_wait_done", done, 2'b00); check("t1_wait_busy", busy, 1'b1);
    tick(); check("t1_done", done, 2'b01); check("t1_rdata", rdata, 16'hBEEF);
    tick(); check("t1_idle", busy, 1'b0); check("t1_no_done", done, 2'b00);

    // Test 2: write idx1 0x00040 <- 0x0007, then read back via idx0.
    set_req(1, 1'b1, 19'h00040, 16'h0007, 1'b0);
    tick(); check("t2_gnt", gnt, 2'b10); check("t2_we", bram_we, 1'b1);
    check("t2_addr", bram_addr, 19'h00040); check("t2_din", bram_din, 16'h0007); req = 2'b00;
    tick(); check("t2_done", done, 2'b10); check("t2_we_off", bram_we, 1'b0);
    tick(); check("t2_idle", busy, 1'b0);
    set_req(0, 1'b0, 19'h00040, 16'h0, 1'b0);
    tick(); check("t2_rb_gnt", gnt, 2'b01); req = 2'b00;
    tick();
    tick(); check("t2_rb_done", done, 2'b01); check("t2_rb_rdata", rdata, 16'h0007);
    tick();

    // Test 3: both requesting continuously after reset -> strict alternation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 19'h00300, 16'h1000, 1'b0);
    set_req(1, 1'b0, 19'h00300, 16'h0, 1'b0);
    g = 0; g0 = 0; g1 = 0;
    for (int k = 0; k < 600 && g < 100; k++) begin
      tick();
      if (gnt != 2'b00) begin
        check("t3_alternate", gnt, (g % 2 == 0) ? 2'b01 : 2'b10);
        if (gnt[0]) begin g0++; wdata[DW-1:0] = wdata[DW-1:0] + 16'h1; end
        else g1++;
        g++;
      end
    end
    req = 2'b00;
    check("t3_grants", g, 100);
    check("t3_grants0", g0, 50);
    check("t3_grants1", g1, 50);
    wait_idle();

    // Test 4: idx0 locked read-modify-write while idx1 waits.
    set_req(0, 1'b0, 19'h00040, 16'h0, 1'b1);
    tick(); check("t4_gnt_rd", gnt, 2'b01); req[0] = 1'b0;
    set_req(1, 1'b0, 19'h00055, 16'h0, 1'b0);
    tick(); check("t4_wait_gnt", gnt, 2'b00);
    tick(); check("t4_done_rd", done, 2'b01); check("t4_rdata", rdata, 16'h0007);
    tick(); check("t4_locked_gnt", gnt, 2'b00); check("t4_locked_busy", busy, 1'b1);
    set_req(0, 1'b1, 19'h00040, 16'h0008, 1'b1);
    tick(); check("t4_gnt_wr", gnt, 2'b01); check("t4_din", bram_din, 16'h0008);
    req[0] = 1'b0; lock[0] = 1'b0;
    tick(); check("t4_done_wr", done, 2'b01); check("t4_resp_gnt", gnt, 2'b00);
    tick(); check("t4_idle_gnt", gnt, 2'b00); check("t4_idle_busy", busy, 1'b0);
    tick(); check("t4_gnt1", gnt, 2'b10); req[1] = 1'b0;
    tick();
    tick(); check("t4_done1", done, 2'b10); check("t4_rdata1", rdata, 16'h0000);
    wait_idle();

    // Test 5: idx0 locks then idles -> forced release after MH cycles.
    set_req(0, 1'b1, 19'h00060, 16'h0011, 1'b1);
    tick(); check("t5_gnt", gnt, 2'b01); req[0] = 1'b0;
    tick(); check("t5_done", done, 2'b01);
    tick(); check("t5_locked", busy, 1'b1);
    set_req(1, 1'b0, 19'h00060, 16'h0, 1'b0);
    for (int i = 0; i < MH - 1; i++) begin
      tick(); check("t5_hold_lt", lock_timeout, 1'b0); check("t5_hold_gnt", gnt, 2'b00);
    end
    tick(); check("t5_lt", lock_timeout, 1'b1); check("t5_lt_busy", busy, 1'b0); lock[0] = 1'b0;
    tick(); check("t5_gnt1", gnt, 2'b10); check("t5_lt_off", lock_timeout, 1'b0); req[1] = 1'b0;
    tick();
    tick(); check("t5_done1", done, 2'b10); check("t5_rdata1", rdata, 16'h0011);
    wait_idle();

    // Test 6: reset during the WAIT of a read, then a fresh read.
    set_req(0, 1'b0, 19'h00123, 16'h0, 1'b0);
    tick(); check("t6_gnt", gnt, 2'b01); req = 2'b00;
    tick(); rst = 1'b1;
    tick();
    check("t6_busy", busy, 1'b0); check("t6_done", done, 2'b00);
    check("t6_rdata", rdata, 16'h0000); check("t6_addr", bram_addr, 19'h0);
    check("t6_we", bram_we, 1'b0); check("t6_lt", lock_timeout, 1'b0);
    rst = 1'b0;
    tick(); check("t6_no_done_a", done, 2'b00);
    tick(); check("t6_no_done_b", done, 2'b00);
    set_req(0, 1'b0, 19'h00123, 16'h0, 1'b0);
    tick(); check("t6_re_gnt", gnt, 2'b01); req = 2'b00;
    tick(); check("t6_re_wait", done, 2'b00);
    tick(); check("t6_re_done", done, 2'b01); check("t6_re_rdata", rdata, 16'hBEEF);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
